// File: rtl/stick_frame_ctrl.sv
// Stick acquisition frame sequencer: sync edge -> pre-delay -> tx pulse -> ACQ_LEN sample strobes -> done.
// o_busy rises on the third clock edge that samples i_sync high; no backpressure, edges seen mid-frame are dropped and flagged.
module stick_frame_ctrl #(
   parameter int DELAY_CYC  = 16,
   parameter int PULSE_CYC  = 20,
   parameter int ACQ_LEN    = 1024,
   parameter int SAMPLE_DIV = 4,
   parameter int IDX_W      = 10
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             i_sync,
   output logic             o_busy,
   output logic             o_tx_pulse,
   output logic             o_sample_strb,
   output logic [IDX_W-1:0] o_sample_idx,
   output logic             o_frame_done,
   output logic [15:0]      o_frame_cnt,
   output logic             o_sync_miss
);

   localparam int CNT_MAX = (DELAY_CYC > PULSE_CYC) ? DELAY_CYC : PULSE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = $clog2(SAMPLE_DIV + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_PULSE,
      S_ACQ,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_sync3;
   logic [CNT_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [IDX_W-1:0] r_idx;
   logic [15:0]      r_frame_cnt;
   logic             w_rise;
   logic             w_cnt_zero;
   logic             w_div_last;
   logic             w_idx_last;
   logic             w_strb;

   // r_sync1/r_sync2 resolve metastability; r_sync3 is the previous value for edge detection
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= i_sync;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_rise     = r_sync2 & ~r_sync3;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_div_last = (r_div == DIV_W'(SAMPLE_DIV - 1));
   assign w_idx_last = (r_idx == IDX_W'(ACQ_LEN - 1));

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_rise)                   w_state_nxt = S_DELAY;
         S_DELAY: if (w_cnt_zero)               w_state_nxt = S_PULSE;
         S_PULSE: if (w_cnt_zero)               w_state_nxt = S_ACQ;
         S_ACQ:   if (w_div_last && w_idx_last) w_state_nxt = S_DONE;
         S_DONE:                                w_state_nxt = S_IDLE;
         default:                               w_state_nxt = S_IDLE;
      endcase
   end

   // r_cnt counts down the remaining cycles of DELAY/PULSE; it is loaded on entry to each phase
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_div       <= '0;
         r_idx       <= '0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_cnt <= CNT_W'(DELAY_CYC - 1);
               end
            end
            S_DELAY: begin
               if (w_cnt_zero) begin
                  r_cnt <= CNT_W'(PULSE_CYC - 1);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_PULSE: begin
               r_div <= '0;
               r_idx <= '0;
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_ACQ: begin
               if (w_div_last) begin
                  r_div <= '0;
                  // count lands on the DONE cycle itself, alongside o_frame_done
                  if (w_idx_last) begin
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign w_strb        = (r_state == S_ACQ) && (r_div == '0);
   assign o_busy        = (r_state == S_DELAY) || (r_state == S_PULSE) || (r_state == S_ACQ);
   assign o_tx_pulse    = (r_state == S_PULSE);
   assign o_sample_strb = w_strb;
   assign o_sample_idx  = w_strb ? r_idx : '0;
   assign o_frame_done  = (r_state == S_DONE);
   assign o_frame_cnt   = r_frame_cnt;
   assign o_sync_miss   = w_rise && (r_state != S_IDLE);

endmodule

// File: tb/tb_stick_frame_ctrl.sv
// Bench for stick_frame_ctrl: default-parameter DUT plus a corner-parameter DUT, checked against an arithmetic frame timeline.
module tb_stick_frame_ctrl;

   localparam int D = 16;
   localparam int P = 20;
   localparam int L = 1024;
   localparam int S = 4;
   localparam int FRAME = D + P + L * S;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        i_sync;
   logic        o_busy, o_tx_pulse, o_sample_strb, o_frame_done, o_sync_miss;
   logic [9:0]  o_sample_idx;
   logic [15:0] o_frame_cnt;

   logic        c_sync;
   logic        c_busy, c_tx, c_strb, c_done, c_miss;
   logic [0:0]  c_idx;
   logic [15:0] c_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat     = 0;
   int model_cnt = 0;

   int q_strb_cyc[$];
   int q_strb_idx[$];
   int q_tx_cyc[$];
   int q_done_cyc[$];
   int q_done_cnt[$];
   int q_miss_cyc[$];
   int q_busy_rise[$];
   int q_busy_fall[$];
   bit prev_busy = 1'b0;

   stick_frame_ctrl #(.DELAY_CYC(D), .PULSE_CYC(P), .ACQ_LEN(L), .SAMPLE_DIV(S), .IDX_W(10)) u_dut (
      .sys_clk(sys_clk), .rst(rst), .i_sync(i_sync),
      .o_busy(o_busy), .o_tx_pulse(o_tx_pulse), .o_sample_strb(o_sample_strb),
      .o_sample_idx(o_sample_idx), .o_frame_done(o_frame_done),
      .o_frame_cnt(o_frame_cnt), .o_sync_miss(o_sync_miss)
   );

   stick_frame_ctrl #(.DELAY_CYC(1), .PULSE_CYC(1), .ACQ_LEN(1), .SAMPLE_DIV(1), .IDX_W(1)) u_corner (
      .sys_clk(sys_clk), .rst(rst), .i_sync(c_sync),
      .o_busy(c_busy), .o_tx_pulse(c_tx), .o_sample_strb(c_strb),
      .o_sample_idx(c_idx), .o_frame_done(c_done),
      .o_frame_cnt(c_cnt), .o_sync_miss(c_miss)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (o_sample_strb) begin
         q_strb_cyc.push_back(cyc);
         q_strb_idx.push_back(int'(o_sample_idx));
      end
      if (o_tx_pulse) q_tx_cyc.push_back(cyc);
      if (o_frame_done) begin
         q_done_cyc.push_back(cyc);
         q_done_cnt.push_back(int'(o_frame_cnt));
      end
      if (o_sync_miss) q_miss_cyc.push_back(cyc);
      if (o_busy && !prev_busy) q_busy_rise.push_back(cyc);
      if (!o_busy && prev_busy) q_busy_fall.push_back(cyc);
      prev_busy = o_busy;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit (cyc=%0d)", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic clear_q();
      q_strb_cyc.delete(); q_strb_idx.delete(); q_tx_cyc.delete();
      q_done_cyc.delete(); q_done_cnt.delete(); q_miss_cyc.delete();
      q_busy_rise.delete(); q_busy_fall.delete();
   endtask

   // Drives one sync pulse (optionally a second, mid-frame one) and checks the whole frame against its timeline.
   task automatic frame_scenario(input string tag, input int width, input int miss_at);
      int n, b, m, t, t_done, d_exp, bad, first_bad, tx_first, tx_last, fall;
      clear_q();
      b = -1; m = -1; t_done = -1;
      model_cnt = (model_cnt + 1) % 65536;
      i_sync = 1'b1;
      n = cyc;
      for (t = 1; t <= 9000; t++) begin
         tick();
         if (t == width) i_sync = 1'b0;
         if (b < 0 && q_busy_rise.size() > 0) b = q_busy_rise[0];
         if (miss_at >= 0 && b >= 0 && m < 0 && cyc == b + miss_at) begin
            i_sync = 1'b1;
            m = cyc;
         end
         if (m >= 0 && cyc == m + 3) i_sync = 1'b0;
         if (t_done < 0 && q_done_cyc.size() > 0) t_done = t;
         if (t_done >= 0 && t >= t_done + 10 && t > width && (miss_at < 0 || (m >= 0 && cyc > m + 3))) break;
      end
      i_sync = 1'b0;
      n_tests++;
      if (t_done < 0) begin
         n_fail++;
         $display("FAIL %s timeout: no frame_done within budget (busy_rise=%0d)", tag, b);
         return;
      end
      n_tests++;
      if (b - n < 3 || b - n > 4) begin
         n_fail++;
         $display("FAIL %s busy_latency: got %0d cycles, want 3..4", tag, b - n);
      end
      if (lat == 0) begin
         lat = b - n;
      end else begin
         n_tests++;
         if (b - n != lat) begin
            n_fail++;
            $display("FAIL %s latency_stable: got %0d, want %0d", tag, b - n, lat);
         end
      end
      d_exp = b + FRAME;
      n_tests++;
      if (q_busy_rise.size() != 1) begin
         n_fail++;
         $display("FAIL %s busy_rises: got %0d, want 1", tag, q_busy_rise.size());
      end
      fall = (q_busy_fall.size() > 0) ? q_busy_fall[0] : -1;
      n_tests++;
      if (fall != d_exp) begin
         n_fail++;
         $display("FAIL %s busy_fall_cycle: got %0d, want %0d", tag, fall, d_exp);
      end
      n_tests++;
      if (q_tx_cyc.size() != P) begin
         n_fail++;
         $display("FAIL %s tx_width: got %0d, want %0d", tag, q_tx_cyc.size(), P);
      end
      tx_first = (q_tx_cyc.size() > 0) ? q_tx_cyc[0] : -1;
      tx_last  = (q_tx_cyc.size() > 0) ? q_tx_cyc[q_tx_cyc.size() - 1] : -1;
      n_tests++;
      if (tx_first != b + D || tx_last != b + D + P - 1) begin
         n_fail++;
         $display("FAIL %s tx_window: got %0d..%0d, want %0d..%0d", tag, tx_first, tx_last, b + D, b + D + P - 1);
      end
      n_tests++;
      if (q_strb_cyc.size() != L) begin
         n_fail++;
         $display("FAIL %s strobe_count: got %0d, want %0d", tag, q_strb_cyc.size(), L);
      end
      bad = 0; first_bad = -1;
      for (int i = 0; i < q_strb_cyc.size(); i++) begin
         if (q_strb_cyc[i] != b + D + P + S * i || q_strb_idx[i] != i) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s strobe_seq: %0d bad, first #%0d at cyc %0d idx %0d, want cyc %0d idx %0d", tag, bad,
                  first_bad, q_strb_cyc[first_bad], q_strb_idx[first_bad], b + D + P + S * first_bad, first_bad);
      end
      n_tests++;
      if (q_done_cyc.size() != 1 || q_done_cyc[0] != d_exp) begin
         n_fail++;
         $display("FAIL %s frame_done: got %0d pulses first at %0d, want 1 at %0d", tag, q_done_cyc.size(), q_done_cyc[0], d_exp);
      end
      n_tests++;
      if (q_done_cnt[0] != model_cnt) begin
         n_fail++;
         $display("FAIL %s frame_cnt: got %0d, want %0d", tag, q_done_cnt[0], model_cnt);
      end
      n_tests++;
      if (miss_at < 0) begin
         if (q_miss_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL %s sync_miss: got %0d pulses, want 0", tag, q_miss_cyc.size());
         end
      end else if (q_miss_cyc.size() != 1 || q_miss_cyc[0] != m + lat - 1) begin
         n_fail++;
         $display("FAIL %s sync_miss: got %0d pulses first at %0d, want 1 at %0d", tag, q_miss_cyc.size(),
                  (q_miss_cyc.size() > 0) ? q_miss_cyc[0] : -1, m + lat - 1);
      end
   endtask

   task automatic test_reset();
      logic [30:0] v;
      rst = 1'b1;
      repeat (2) tick();
      v = {o_busy, o_tx_pulse, o_sample_strb, o_frame_done, o_sync_miss, o_sample_idx, o_frame_cnt};
      n_tests++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, want 0", v);
      end
      v = {c_busy, c_tx, c_strb, c_done, c_miss, 9'd0, c_idx, c_cnt};
      n_tests++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL reset_corner_outputs: got %h, want 0", v);
      end
      rst = 1'b0;
      clear_q();
      repeat (1000) tick();
      n_tests++;
      if (q_strb_cyc.size() + q_tx_cyc.size() + q_done_cyc.size() + q_miss_cyc.size() + q_busy_rise.size() != 0) begin
         n_fail++;
         $display("FAIL idle_quiet: got strb=%0d tx=%0d done=%0d miss=%0d busy=%0d, want all 0", q_strb_cyc.size(),
                  q_tx_cyc.size(), q_done_cyc.size(), q_miss_cyc.size(), q_busy_rise.size());
      end
   endtask

   task automatic test_single_sync();
      frame_scenario("single", 20, -1);
   endtask

   task automatic test_retrigger();
      frame_scenario("retrigger", 20, 200);
      frame_scenario("retrigger_rand", $urandom_range(2, 20), $urandom_range(150, 3000));
   endtask

   task automatic test_miss_in_done();
      // second edge timed so its rise is detected exactly in the DONE cycle
      frame_scenario("miss_in_done", $urandom_range(2, 10), FRAME - (lat - 1));
   endtask

   task automatic test_back_to_back();
      frame_scenario("back_to_back", $urandom_range(2, 8), -1);
   endtask

   task automatic test_long_sync();
      frame_scenario("long_sync", FRAME + 300, -1);
   endtask

   task automatic test_abort();
      int k, t;
      logic [30:0] v;
      clear_q();
      k = $urandom_range(1, 1000);
      i_sync = 1'b1;
      for (t = 0; t < 6000 && q_strb_cyc.size() < k; t++) begin
         tick();
         if (t == 2) i_sync = 1'b0;
      end
      i_sync = 1'b0;
      n_tests++;
      if (q_strb_cyc.size() < k) begin
         n_fail++;
         $display("FAIL abort_reach_acq: got %0d strobes, want %0d", q_strb_cyc.size(), k);
      end
      rst = 1'b1;
      tick();
      v = {o_busy, o_tx_pulse, o_sample_strb, o_frame_done, o_sync_miss, o_sample_idx, o_frame_cnt};
      n_tests++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: got %h, want 0", v);
      end
      rst = 1'b0;
      model_cnt = 0;
      repeat (300) tick();
      n_tests++;
      if (q_done_cyc.size() != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d frame_done pulses, want 0", q_done_cyc.size());
      end
      frame_scenario("post_abort", $urandom_range(2, 20), -1);
   endtask

   task automatic test_corner_params();
      logic cb[20], ct[20], cs[20], cd[20], cm[20];
      int   ci[20], cc[20];
      int   b, e_busy, e_tx, e_strb, e_done, e_miss;
      for (int j = 0; j < 20; j++) begin
         cb[j] = 0; ct[j] = 0; cs[j] = 0; cd[j] = 0; cm[j] = 0; ci[j] = -1; cc[j] = -1;
      end
      c_sync = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         tick();
         if (j == 3) c_sync = 1'b0;
         cb[j] = c_busy; ct[j] = c_tx; cs[j] = c_strb; cd[j] = c_done; cm[j] = c_miss;
         ci[j] = int'(c_idx); cc[j] = int'(c_cnt);
      end
      b = 0;
      for (int j = 16; j >= 1; j--) if (cb[j]) b = j;
      n_tests++;
      if (b != lat) begin
         n_fail++;
         $display("FAIL corner_latency: got %0d, want %0d", b, lat);
      end
      if (b < 1) b = 1;
      e_busy = 0; e_tx = 0; e_strb = 0; e_done = 0; e_miss = 0;
      for (int j = 1; j <= 16; j++) begin
         if (cb[j] != (j >= b && j <= b + 2)) e_busy++;
         if (ct[j] != (j == b + 1)) e_tx++;
         if (cs[j] != (j == b + 2)) e_strb++;
         if (cd[j] != (j == b + 3)) e_done++;
         if (cm[j]) e_miss++;
      end
      n_tests++;
      if (e_busy != 0) begin n_fail++; $display("FAIL corner_busy: got %0d wrong cycles, want 0", e_busy); end
      n_tests++;
      if (e_tx != 0) begin n_fail++; $display("FAIL corner_tx: got %0d wrong cycles, want 0", e_tx); end
      n_tests++;
      if (e_strb != 0) begin n_fail++; $display("FAIL corner_strobe: got %0d wrong cycles, want 0", e_strb); end
      n_tests++;
      if (e_done != 0) begin n_fail++; $display("FAIL corner_done: got %0d wrong cycles, want 0", e_done); end
      n_tests++;
      if (e_miss != 0) begin n_fail++; $display("FAIL corner_miss: got %0d pulses, want 0", e_miss); end
      n_tests++;
      if (ci[b + 2] != 0) begin n_fail++; $display("FAIL corner_idx: got %0d, want 0", ci[b + 2]); end
      n_tests++;
      if (cc[b + 3] != 1) begin n_fail++; $display("FAIL corner_cnt: got %0d, want 1", cc[b + 3]); end
   endtask

   initial begin
      rst    = 1'b1;
      i_sync = 1'b0;
      c_sync = 1'b0;
      test_reset();
      test_single_sync();
      test_retrigger();
      test_miss_in_done();
      test_back_to_back();
      test_long_sync();
      test_abort();
      test_corner_params();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
